// File: rtl/dmem_rmw_port_pkg.sv
// Shared funct3 codes, FSM state encoding and the request legality rule
// for the RV32I data-memory load/store front-end.
package dmem_rmw_port_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MRG  = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  // Stores only allow B/H/W; loads add BU/HU. H needs even, W word alignment.
  function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !a[0];
      F3_HU:   ok = !we && !a[0];
      F3_W:    ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rmw_port_lane_align.sv
// Lane logic: extract + sign/zero extend the addressed lane for loads, and
// merge store data into the addressed lane of the old word for SB/SH.
module dmem_lane_align
  import dmem_rmw_port_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (addr_lo_i)
      2'd0: byte_v = word_i[7:0];
      2'd1: byte_v = word_i[15:8];
      2'd2: byte_v = word_i[23:16];
      2'd3: byte_v = word_i[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_o = {24'h000000, byte_v};
      F3_H:    load_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_o = {16'h0000, half_v};
      default: load_o = word_i;
    endcase
  end

  // Only the addressed lane changes; the rest of the old word passes through.
  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (addr_lo_i)
          2'd0: merge_o[7:0]   = wdata_i[7:0];
          2'd1: merge_o[15:8]  = wdata_i[7:0];
          2'd2: merge_o[23:16] = wdata_i[7:0];
          2'd3: merge_o[31:24] = wdata_i[7:0];
          default: merge_o = word_i;
        endcase
      end
      F3_H: begin
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_port.sv
// Load/store front-end for a single-port synchronous word BRAM: sub-word
// stores become read-modify-write, loads are lane-extracted and extended.
module dmem_rmw_port
  import dmem_rmw_port_pkg::*;
#(
  parameter int DEPTH_LOG = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [31:0]          rsp_rdata,
  output logic [DEPTH_LOG-1:0] mem_addr,
  output logic                 mem_en,
  output logic [31:0]          mem_di,
  input  logic [31:0]          mem_do,
  output state_e               dbg_state
);

  if (DEPTH != (1 << DEPTH_LOG)) begin : g_bad_depth
    $error("DEPTH must equal 2**DEPTH_LOG");
  end

  // Handshake: a request transfers on a posedge where req_valid & req_ready;
  // req_ready is a register that is high only while idle. rsp_valid is a
  // single-cycle pulse with no back-pressure.

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [DEPTH_LOG+1:0]  addr_q;
  logic [31:0]           wdata_q;
  logic                  accept;
  logic [31:0]           load_data;
  logic [31:0]           merge_data;
  logic                  unused_addr_hi;

  // Upper address bits wrap modulo DEPTH words and are deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:DEPTH_LOG+2];

  assign accept    = req_valid && ready_q;
  assign req_ready = ready_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!req_legal(req_we, req_funct3, req_addr[1:0])) state_d = S_ERR;
          else if (req_we && req_funct3 == F3_W)             state_d = S_WR;
          else                                                state_d = S_RD;
        end
      end
      S_RD:    state_d = S_MRG;
      S_MRG:   state_d = S_IDLE;
      S_WR:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[DEPTH_LOG+1:0];
        wdata_q <= req_wdata;
      end
    end
  end

  dmem_lane_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .word_i    (mem_do),
    .wdata_i   (wdata_q),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

  always_comb begin
    mem_addr  = addr_q[DEPTH_LOG+1:2];
    mem_en    = 1'b0;
    mem_di    = 32'h0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    case (state_q)
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      S_WR: begin
        mem_en    = 1'b1;
        mem_di    = wdata_q;
        rsp_valid = 1'b1;
      end
      S_MRG: begin
        rsp_valid = 1'b1;
        if (we_q) begin
          mem_en = 1'b1;
          mem_di = merge_data;
        end else begin
          rsp_rdata = load_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_rmw_port.sv
// Bench for dmem_rmw_port: byte-level memory model, per-cycle response checker,
// directed lane/legality/abort cases followed by randomized traffic.
module tb_dmem_rmw_port;
  import dmem_rmw_port_pkg::*;

  localparam int DL    = 8;
  localparam int DEPTH = 256;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    logic        wen;
    logic [7:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;
  logic [DL-1:0] mem_addr;
  logic          mem_en;
  logic [31:0]   mem_di;
  logic [31:0]   mem_do;
  state_e        dbg_state;

  logic [31:0] bram [DEPTH];
  logic [31:0] model_mem [DEPTH];
  exp_t        exp_q[$];
  int          pcnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  always @(posedge clk) begin
    if (mem_en) bram[mem_addr] <= mem_di;
    mem_do <= bram[mem_addr];
  end

  dmem_rmw_port #(.DEPTH_LOG(DL), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_di     (mem_di),
    .mem_do     (mem_do),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < pcnt) begin
      check("rsp_missing_cycle", pcnt, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == pcnt) begin
      e = exp_q.pop_front();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, e.err);
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("mem_en", mem_en, e.wen);
      if (e.wen) begin
        check("mem_addr", mem_addr, e.waddr);
        check("mem_di", mem_di, e.wdata);
      end
    end else begin
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_mem_en", mem_en, 0);
      check("idle_rsp_rdata", rsp_rdata, 0);
    end
  end

  // ---------------- driver ----------------
  task automatic wait_accept(output bit ok);
    int waits;
    bit r;
    waits = 0;
    ok = 1'b0;
    forever begin
      r = req_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      waits++;
      if (waits > 20) begin
        check("accept_timeout", waits, 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reference: memory viewed as bytes, access of 1/2/4 bytes at a byte offset.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output exp_t e);
    logic [7:0]  b [4];
    logic [31:0] v;
    int n, off, idx, lat;
    bit legal, ok;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    wait_accept(ok);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    e = '{cyc: 0, err: 1'b0, rdata: 32'h0, wen: 1'b0, waddr: 8'h0, wdata: 32'h0};
    if (!ok) return;
    n     = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    idx   = int'((addr >> 2) % DEPTH);
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (legal && (addr % n) != 0) legal = 1'b0;
    for (int i = 0; i < 4; i++) b[i] = model_mem[idx][8*i +: 8];
    lat = 1;
    if (!legal) begin
      e.err = 1'b1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(b[off+i]) << (8*i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rdata = v;
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++) b[off+i] = wdata[8*i +: 8];
      v = {b[3], b[2], b[1], b[0]};
      model_mem[idx] = v;
      e.wen   = 1'b1;
      e.waddr = 8'(idx);
      e.wdata = v;
      lat = (n == 4) ? 1 : 2;
    end
    e.cyc = pcnt + lat - 1;
    exp_q.push_back(e);
  endtask

  // SB that is accepted and then killed by reset while in the merge cycle.
  task automatic aborted_sb(input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = addr;
    req_wdata  = wdata;
    wait_accept(ok);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mrg_mem_en_before", mem_en, 1);
    resetb = 1'b0;
    #1;
    check("abort_mem_en_dropped", mem_en, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check("abort_word_unchanged", bram[(addr >> 2) % DEPTH], model_mem[(addr >> 2) % DEPTH]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset with a request presented: nothing may happen.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_funct3 = F3_W;
    repeat (3) begin
      @(negedge clk);
      check("rst_mem_en", mem_en, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
    end
    resetb    = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_release", req_ready, 1);

    do_req(1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF, e);
    check("sw_waddr", e.waddr, 4);
    check("sw_wdata", e.wdata, 32'hDEAD_BEEF);
    do_req(1'b0, F3_W, 32'h10, 32'h0, e);
    check("lw_rdata", e.rdata, 32'hDEAD_BEEF);

    do_req(1'b1, F3_B, 32'h13, 32'h0000_0055, e);
    check("sb_merge", e.wdata, 32'h55AD_BEEF);
    do_req(1'b0, F3_B, 32'h13, 32'h0, e);
    check("lb_13", e.rdata, 32'h0000_0055);
    do_req(1'b0, F3_B, 32'h12, 32'h0, e);
    check("lb_12", e.rdata, 32'hFFFF_FFAD);
    do_req(1'b0, F3_BU, 32'h12, 32'h0, e);
    check("lbu_12", e.rdata, 32'h0000_00AD);

    do_req(1'b1, F3_H, 32'h12, 32'h0000_8001, e);
    check("sh_merge", e.wdata, 32'h8001_BEEF);
    do_req(1'b0, F3_H, 32'h12, 32'h0, e);
    check("lh_12", e.rdata, 32'hFFFF_8001);
    do_req(1'b0, F3_HU, 32'h12, 32'h0, e);
    check("lhu_12", e.rdata, 32'h0000_8001);

    do_req(1'b0, F3_W, 32'h11, 32'h0, e);
    check("lw_misaligned_err", e.err, 1);
    do_req(1'b1, F3_H, 32'h13, 32'hFFFF_FFFF, e);
    check("sh_misaligned_err", e.err, 1);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, e);
    check("load_f3_3_err", e.err, 1);
    do_req(1'b0, F3_W, 32'h10, 32'h0, e);
    check("word_after_errs", e.rdata, 32'h8001_BEEF);

    do_req(1'b1, F3_W, 32'h0000_0400, 32'h1234_5678, e);
    check("alias_waddr", e.waddr, 0);
    do_req(1'b0, F3_W, 32'h0, 32'h0, e);
    check("alias_rdata", e.rdata, 32'h1234_5678);

    repeat (4) @(negedge clk);
    aborted_sb(32'h13, 32'h0000_00AA);
    do_req(1'b0, F3_W, 32'h10, 32'h0, e);
    check("post_abort_word", e.rdata, 32'h8001_BEEF);

    // Fill every word so random loads read defined data.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, F3_W, 32'(i * 4), $urandom, e);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
      do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < DEPTH; i++) check("final_mem", bram[i], model_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
